// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch buffer between fetch and decode
module fetch_queue #(
    parameter int bit_size   = 18,
    parameter int instr_size = 32,
    parameter int depth      = 4,
    parameter int cnt_size   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fetch_valid,
    input  logic [bit_size-1:0]     fetch_pc,
    input  logic [instr_size-1:0]   fetch_instr,
    output logic                    fetch_stall,
    input  logic                    flush,
    input  logic                    id_ready,
    output logic                    id_valid,
    output logic [bit_size-1:0]     id_pc,
    output logic [bit_size-1:0]     id_pc_plus4,
    output logic [instr_size-1:0]   id_instr,
    output logic [$clog2(depth):0]  count,
    output logic [cnt_size-1:0]     drop_cnt
);

    localparam int aw = $clog2(depth);
    localparam int cw = aw + 1;
    localparam int sw = cnt_size + cw;
    localparam logic [cnt_size-1:0] cnt_max = '1;

    logic [bit_size-1:0]   pc_mem    [depth];
    logic [instr_size-1:0] instr_mem [depth];
    logic [aw-1:0]         rd_ptr;
    logic [aw-1:0]         wr_ptr;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic [sw-1:0]         drop_sum;
    logic [cnt_size-1:0]   drop_next;

    assign full        = (count == cw'(depth));
    assign fetch_stall = full;
    assign push        = fetch_valid & ~full;
    assign id_valid    = (count != '0);
    assign pop         = id_valid & id_ready;

    // Empty queue presents a NOP bubble at PC 0 rather than stale storage.
    always_comb begin
        id_pc    = '0;
        id_instr = '0;
        if (id_valid) begin
            id_pc    = pc_mem[rd_ptr];
            id_instr = instr_mem[rd_ptr];
        end
        id_pc_plus4 = id_pc + bit_size'(4);
    end

    always_comb begin
        drop_sum  = sw'(drop_cnt) + sw'(count);
        drop_next = (drop_sum > sw'(cnt_max)) ? cnt_max : drop_sum[cnt_size-1:0];
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + aw'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + aw'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + cw'(1);
                2'b01:   count <= count - cw'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < depth; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (!flush && push) begin
            pc_mem[wr_ptr]    <= fetch_pc;
            instr_mem[wr_ptr] <= fetch_instr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= '0;
        end else if (flush) begin
            drop_cnt <= drop_next;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue
module tb_fetch_queue;

    localparam int BS   = 18;
    localparam int IS   = 32;
    localparam int DEP  = 4;
    localparam int CS   = 2;
    localparam int CMAX = 3;

    logic          clk;
    logic          rst;
    logic          fetch_valid;
    logic [BS-1:0] fetch_pc;
    logic [IS-1:0] fetch_instr;
    logic          fetch_stall;
    logic          flush;
    logic          id_ready;
    logic          id_valid;
    logic [BS-1:0] id_pc;
    logic [BS-1:0] id_pc_plus4;
    logic [IS-1:0] id_instr;
    logic [2:0]    count;
    logic [CS-1:0] drop_cnt;

    fetch_queue #(.bit_size(BS), .instr_size(IS), .depth(DEP), .cnt_size(CS)) dut (
        .clk(clk), .rst(rst),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
        .fetch_stall(fetch_stall), .flush(flush), .id_ready(id_ready),
        .id_valid(id_valid), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
        .id_instr(id_instr), .count(count), .drop_cnt(drop_cnt)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of {pc, instr} pairs plus a drop total.
    typedef struct packed {
        logic [BS-1:0] pc;
        logic [IS-1:0] instr;
    } ent_t;

    ent_t            mq[$];
    int              mdrop = 0;
    logic [BS-1:0]   dut_seen[$];
    bit              m_pop;
    bit              m_push;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            mdrop = 0;
        end else if (flush) begin
            mdrop = (mdrop + mq.size() > CMAX) ? CMAX : mdrop + mq.size();
            mq.delete();
        end else begin
            m_pop  = (mq.size() != 0) && id_ready;
            m_push = fetch_valid && (mq.size() != DEP);
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back('{pc: fetch_pc, instr: fetch_instr});
        end
    end

    logic [BS-1:0] e_pc;
    logic [IS-1:0] e_instr;

    always @(negedge clk) begin
        e_pc    = (mq.size() != 0) ? mq[0].pc : '0;
        e_instr = (mq.size() != 0) ? mq[0].instr : '0;
        chk("id_valid", id_valid, mq.size() != 0);
        chk("id_pc", id_pc, e_pc);
        chk("id_pc_plus4", id_pc_plus4, BS'(e_pc + BS'(4)));
        chk("id_instr", id_instr, e_instr);
        chk("count", count, mq.size());
        chk("fetch_stall", fetch_stall, mq.size() == DEP);
        chk("drop_cnt", drop_cnt, mdrop);
        if (rst && !flush && id_valid && id_ready) dut_seen.push_back(id_pc);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [BS-1:0] pc);
        fetch_valid = v;
        fetch_pc    = pc;
        fetch_instr = 32'hA000_0000 | IS'(pc);
    endtask

    task automatic fill_and_flush();
        id_ready = 0;
        for (int i = 0; i < DEP; i++) begin
            drive(1, BS'(18'h200 + 4 * i));
            step();
        end
        drive(0, '0);
        flush = 1;
        step();
        flush = 0;
    endtask

    initial begin
        rst = 0; flush = 0; id_ready = 0;
        fetch_valid = 1; fetch_pc = 18'h4; fetch_instr = 32'h2008_0005;
        #23;
        chk("rst_valid", id_valid, 0);
        chk("rst_instr", id_instr, 0);
        chk("rst_plus4", id_pc_plus4, 4);
        chk("rst_count", count, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_stall", fetch_stall, 0);
        rst = 1;
        step();
        chk("first_pc", id_pc, 18'h4);
        chk("first_plus4", id_pc_plus4, 18'h8);
        chk("first_instr", id_instr, 32'h2008_0005);

        for (int i = 2; i <= 4; i++) begin
            drive(1, BS'(4 * i));
            step();
        end
        chk("full_count", count, 4);
        chk("full_stall", fetch_stall, 1);
        drive(1, 18'd20);
        step();
        chk("refused_count", count, 4);
        chk("refused_head", id_pc, 18'd4);

        id_ready = 1;
        step();
        chk("fullpop_count", count, 3);
        chk("fullpop_stall", fetch_stall, 0);
        chk("fullpop_head", id_pc, 18'd8);
        id_ready = 0;
        step();
        chk("refill_count", count, 4);

        drive(0, '0);
        id_ready = 1;
        for (int i = 0; i < 4; i++) step();
        chk("drained_count", count, 0);
        chk("drained_plus4", id_pc_plus4, 4);
        dut_seen.delete();

        for (int i = 0; i < 12; i++) begin
            drive(1, BS'(4 + 4 * i));
            step();
            chk("stream_count", count, 1);
        end
        drive(0, '0);
        step();
        chk("stream_len", dut_seen.size(), 12);
        for (int i = 0; i < 12 && i < dut_seen.size(); i++)
            chk("stream_order", dut_seen[i], BS'(4 + 4 * i));

        id_ready = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1, BS'(18'h100 + 4 * i));
            step();
        end
        dut_seen.delete();
        drive(1, 18'h10c);
        id_ready = 1;
        flush = 1;
        step();
        flush = 0; id_ready = 0;
        drive(0, '0);
        chk("flush_count", count, 0);
        chk("flush_valid", id_valid, 0);
        chk("flush_drop", drop_cnt, 3);
        chk("flush_nopop", dut_seen.size(), 0);

        drive(1, 18'h300);
        step();
        step();
        drive(0, '0);
        #2 rst = 0;
        #1;
        chk("async_valid", id_valid, 0);
        chk("async_count", count, 0);
        chk("async_drop", drop_cnt, 0);
        chk("async_plus4", id_pc_plus4, 4);
        #3 rst = 1;
        step();

        flush = 1;
        step();
        flush = 0;
        chk("empty_flush_drop", drop_cnt, 0);
        for (int k = 0; k < 3; k++) begin
            fill_and_flush();
            chk("sat_drop", drop_cnt, CMAX);
        end

        drive(1, 18'h44);
        step();
        drive(0, '0);
        #2 rst = 0;
        #1;
        chk("async2_valid", id_valid, 0);
        chk("async2_instr", id_instr, 0);
        chk("async2_drop", drop_cnt, 0);
        #3 rst = 1;
        drive(1, 18'h40);
        step();
        drive(0, '0);
        chk("post_rst_pc", id_pc, 18'h40);
        chk("post_rst_count", count, 1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch buffer between the PC / instruction-memory fetch path and the ID stage.
- Captures each fetched {PC, instruction} pair into a small FIFO and presents the oldest entry to decode with a valid/ready handshake.
- Raises a stall to the PC when full.
- Discards all buffered entries on a branch/jump flush and counts the discarded instructions for debug.

Parameters:
- bit_size, 18: PC / instruction address width.
- instr_size, 32: instruction word width.
- depth, 4: number of queue entries; power of two, at least 2.
- cnt_size, 16: width of the flush-drop counter.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- fetch_valid  input  1  fetch side presents a valid pair this cycle.
- fetch_pc  input  bit_size  address of the fetched instruction (PC output).
- fetch_instr  input  instr_size  instruction word read at fetch_pc.
- fetch_stall  output  1  queue full; PC must hold (drives PCWrite logic).
- flush  input  1  branch/jump redirect; drop all buffered entries.
- id_ready  input  1  ID stage accepts the head entry this cycle.
- id_valid  output  1  head entry is valid.
- id_pc  output  bit_size  PC of the head entry.
- id_pc_plus4  output  bit_size  id_pc + 4, modulo 2^bit_size.
- id_instr  output  instr_size  instruction of the head entry.
- count  output  log2(depth)+1  current occupancy, 0..depth.
- drop_cnt  output  cnt_size  cumulative entries discarded by flush; saturating.

Behaviour:
- Reset (rst=0, asynchronous, independent of clk):
  - count=0, read/write pointers=0, all storage=0, drop_cnt=0.
  - Hence id_valid=0, id_pc=0, id_pc_plus4=4, id_instr=0, fetch_stall=0.
- push = fetch_valid & (count != depth).
  - When count==depth, a fetch pair is not accepted and is not stored; the fetch side must re-present it.
- pop = id_valid & id_ready.
- fetch_stall = (count == depth).
  - Purely a function of registered count; no combinational path from id_ready or fetch_valid.
- id_valid = (count != 0).
- Head-entry outputs:
  - id_pc and id_instr are a combinational read of the entry at the read pointer when count != 0.
  - When count == 0, id_pc = 0 and id_instr = 0 (NOP bubble); id_pc_plus4 = 4.
- Push:
  - Writes {fetch_pc, fetch_instr} at the write pointer.
  - Write pointer increments modulo depth (wrap-around).
- Pop:
  - Read pointer increments modulo depth.
- Occupancy:
  - push only: count+1.
  - pop only: count-1.
  - push and pop in the same cycle: count unchanged, both pointers advance.
  - Full plus pop: push is still refused that cycle (fetch_stall was 1). The freed slot is usable next cycle, when fetch_stall drops.
- Latency: an entry pushed at edge N is visible on id_* after edge N (zero extra cycles); it is poppable in the cycle after its push.
- Flush (synchronous, highest priority):
  - Next edge sets count=0 and both pointers=0.
  - push and pop in that cycle are ignored; the fetch pair presented in the flush cycle is discarded.
  - Storage contents are not cleared.
  - drop_cnt += count (pre-flush occupancy), saturating at 2^cnt_size-1.
  - Flush on an empty queue leaves drop_cnt unchanged.
- Reset asserted mid-operation overrides everything immediately. The first edge after rst returns to 1 behaves as from an empty queue.

Test Plan:
- Reset: hold rst=0 with fetch_valid=1 → id_valid=0, id_instr=0, id_pc_plus4=4, count=0, drop_cnt=0. Release rst → first push of pc=0x00004, instr=0x20080005 appears with id_pc=0x00004, id_pc_plus4=0x00008.
- Fill/full: id_ready=0, push pcs 4, 8, 12, 16 → count=4, fetch_stall=1. Fifth push (pc=20) is ignored; count stays 4; head still pc=4.
- Full plus pop: from full, id_ready=1 for one cycle with fetch_valid=1 → pc=4 popped, pc=20 not stored, count=3, fetch_stall=0. Next cycle pc=20 is pushed, count=4.
- Wrap-around: stream 12 pairs with id_ready=1 and fetch_valid=1 continuously → decode sees pcs in exact order 4..48 with no loss or duplication. Occupancy stays ≤1 after the first cycle and pointers wrap 3→0.
- Flush: with 3 entries buffered, assert flush together with fetch_valid=1 and id_ready=1 → next cycle count=0, id_valid=0, drop_cnt=3. Neither the flush-cycle fetch pair nor the head is consumed.
- Saturation/async reset: with cnt_size=2, flush 3 full queues → drop_cnt=3 (saturated). Then pulse rst=0 mid-cycle → all outputs return to reset values before the next clock edge.
